// File: rtl/bdb_emu_pkg.sv
// bdb_emu_pkg: shared types and constants for the bounce emulator
// Contents: FSM state enum, Galois LFSR tap mask, default parameter values,
//           and the one-step LFSR update used by bdb_lfsr16.
package bdb_emu_pkg;
    typedef enum logic [2:0] {IDLE, PRESS_BOUNCE, HOLD, RELEASE_BOUNCE, GAP} bdb_emu_state_t;
    localparam logic [15:0] LFSR_TAPS        = 16'hB400;
    localparam int          DEF_BOUNCE_COUNT = 3;
    localparam logic [15:0] DEF_BOUNCE_MASK  = 16'h000F;
    localparam int          DEF_HOLD_WIDTH   = 16;
    localparam int          DEF_GAP_CYCLES   = 32;
    localparam logic [15:0] DEF_LFSR_SEED    = 16'hACE1;
    function automatic logic [15:0] lfsr_step(input logic [15:0] q);
        return (q >> 1) ^ (q[0] ? LFSR_TAPS : 16'h0000);
    endfunction
endpackage

// File: rtl/bdb_lfsr16.sv
// bdb_lfsr16: free-running 16-bit Galois LFSR
// Ports: clock (in), reset (in, sync active-high), seed[15:0] (in, 0 maps to 1),
//        q[15:0] (out, current LFSR state, advances every cycle)
module bdb_lfsr16 import bdb_emu_pkg::*; (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] seed,
    output logic [15:0] q
);
    always_ff @(posedge clock)
        q <= reset ? ((seed == 16'h0000) ? 16'h0001 : seed) : lfsr_step(q);
endmodule

// File: rtl/bdb_bounce_emulator.sv
// bdb_bounce_emulator: turns press requests into a bouncy buttonDown waveform
// Ports: clock, reset (sync active-high); req_valid/req_ready handshake with
//        req_hold (stable-press cycles, 0 acts as 1) and req_bounce_en;
//        buttonDown (registered level), stablePress (pulse on first HOLD cycle),
//        busy (not IDLE), pressCount (HOLD entries since reset, wrapping).
module bdb_bounce_emulator import bdb_emu_pkg::*; #(
    parameter int          BOUNCE_COUNT = DEF_BOUNCE_COUNT,
    parameter logic [15:0] BOUNCE_MASK  = DEF_BOUNCE_MASK,
    parameter int          HOLD_WIDTH   = DEF_HOLD_WIDTH,
    parameter int          GAP_CYCLES   = DEF_GAP_CYCLES,
    parameter logic [15:0] LFSR_SEED    = DEF_LFSR_SEED
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [HOLD_WIDTH-1:0] req_hold,
    input  logic                  req_bounce_en,
    output logic                  buttonDown,
    output logic                  stablePress,
    output logic                  busy,
    output logic [15:0]           pressCount
);
    localparam int CW = HOLD_WIDTH > 16 ? HOLD_WIDTH : 16;
    localparam logic [7:0]    SEG_LAST = 8'(2 * BOUNCE_COUNT - 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);
    bdb_emu_state_t state, state_n;
    logic [7:0] seg, seg_n;
    logic [15:0] len_cnt, len_n, lfsr;
    logic [CW-1:0] hg_cnt, hg_n, hold_load;
    logic [HOLD_WIDTH-1:0] hold_q, hold_n, hold_src;
    logic bounce_q, bounce_n, bd_n, sp_n;

    bdb_lfsr16 u_lfsr (.clock(clock), .reset(reset), .seed(LFSR_SEED), .q(lfsr));

    assign req_ready = state == IDLE;
    assign busy      = state != IDLE;
    // HOLD is entered either straight from IDLE (request still on the bus) or after press bounce
    assign hold_src  = (state == IDLE) ? req_hold : hold_q;
    assign hold_load = CW'((hold_src == '0) ? '0 : hold_src - HOLD_WIDTH'(1));

    always_comb begin
        state_n  = state;
        seg_n    = seg;
        len_n    = len_cnt;
        hg_n     = hg_cnt;
        hold_n   = hold_q;
        bounce_n = bounce_q;
        sp_n     = 1'b0;
        case (state)
            IDLE: if (req_valid) begin
                hold_n   = req_hold;
                bounce_n = req_bounce_en;
                seg_n    = '0;
                len_n    = lfsr & BOUNCE_MASK;
                hg_n     = hold_load;
                state_n  = req_bounce_en ? PRESS_BOUNCE : HOLD;
                sp_n     = !req_bounce_en;
            end
            PRESS_BOUNCE, RELEASE_BOUNCE: if (len_cnt != '0) len_n = len_cnt - 16'd1;
            else if (seg == SEG_LAST) begin
                state_n = (state == PRESS_BOUNCE) ? HOLD : GAP;
                hg_n    = (state == PRESS_BOUNCE) ? hold_load : GAP_LOAD;
                sp_n    = state == PRESS_BOUNCE;
            end else begin
                seg_n = seg + 8'd1;
                len_n = lfsr & BOUNCE_MASK;
            end
            HOLD: if (hg_cnt != '0) hg_n = hg_cnt - CW'(1);
            else begin
                state_n = bounce_q ? RELEASE_BOUNCE : GAP;
                seg_n   = '0;
                len_n   = lfsr & BOUNCE_MASK;
                hg_n    = GAP_LOAD;
            end
            GAP: if (hg_cnt != '0) hg_n = hg_cnt - CW'(1);
            else state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // even press segments are high, odd release segments are high
        bd_n = (state_n == HOLD) || (state_n == PRESS_BOUNCE && !seg_n[0]) ||
               (state_n == RELEASE_BOUNCE && seg_n[0]);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            seg         <= '0;
            len_cnt     <= '0;
            hg_cnt      <= '0;
            hold_q      <= '0;
            bounce_q    <= 1'b0;
            buttonDown  <= 1'b0;
            stablePress <= 1'b0;
            pressCount  <= '0;
        end else begin
            state       <= state_n;
            seg         <= seg_n;
            len_cnt     <= len_n;
            hg_cnt      <= hg_n;
            hold_q      <= hold_n;
            bounce_q    <= bounce_n;
            buttonDown  <= bd_n;
            stablePress <= sp_n;
            pressCount  <= pressCount + 16'(sp_n);
        end
    end
endmodule
